wb_arbiter_pipelined: RTL and testbench

//   Round-robin arbiter that shares one Wishbone classic-pipelined slave
//   (single-port RAM, optional wait states) between NM pipelined masters.

---
 rtl/wb_arbiter_pipelined.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter_pipelined.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_pipelined.sv
// Round-robin arbiter sharing one Wishbone classic-pipelined slave between NM masters.
// Ownership lasts a whole CYC; outstanding strobes are counted and drained after an abort.
module wb_arbiter_pipelined #(
  parameter int NM     = 2,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int MAXOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_cyc,
  input  logic [NM-1:0]        m_stb,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*AW-1:0]     m_adr,
  input  logic [NM*DW-1:0]     m_dat_w,
  output logic [DW-1:0]        m_dat_r,
  output logic [NM-1:0]        m_ack,
  output logic [NM-1:0]        m_stall,
  output logic [NM-1:0]        gnt,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [AW-1:0]        s_adr,
  output logic [DW-1:0]        s_dat_w,
  input  logic [DW-1:0]        s_dat_r,
  input  logic                 s_ack,
  input  logic                 s_stall
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = $clog2(MAXOUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAXOUT);
  localparam logic [NM-1:0] ONE_HOT0 = NM'(1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    DRAIN
  } state_t;

  state_t        st;
  logic [IW-1:0] own;
  logic [IW-1:0] rr;
  logic [CW-1:0] cnt;

  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;
  logic          accept;
  logic          ack_hit;
  logic [CW-1:0] cnt_nxt;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    return (v == IW'(NM - 1)) ? '0 : v + 1'b1;
  endfunction

  // Round-robin search starting at rr, wrapping modulo NM.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pick  = rr;
    cand  = rr;
    found = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (!found && m_cyc[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = inc_mod(cand);
    end
  end

  // A slave ACK only counts when something is outstanding; stray ACKs at cnt==0 vanish.
  assign accept  = s_stb & ~s_stall;
  assign ack_hit = s_ack & (cnt != '0);
  assign cnt_nxt = cnt + CW'(accept) - CW'(ack_hit);

  assign m_dat_r = s_dat_r;

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    m_ack   = '0;
    m_stall = m_stb;
    case (st)
      OWN: begin
        s_cyc         = m_cyc[own];
        s_stb         = m_stb[own] & (cnt < MAX_CNT);
        s_we          = m_we[own];
        s_adr         = m_adr[own*AW +: AW];
        s_dat_w       = m_dat_w[own*DW +: DW];
        m_stall[own]  = s_stall | (m_stb[own] & (cnt == MAX_CNT));
        m_ack[own]    = ack_hit;
      end
      DRAIN: begin
        // Keep CYC up so the slave can finish the aborted master's strobes.
        s_cyc = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      own <= '0;
      rr  <= '0;
      cnt <= '0;
      gnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      case (st)
        IDLE: begin
          if (|m_cyc) begin
            own <= pick;
            gnt <= ONE_HOT0 << pick;
            st  <= OWN;
          end
        end
        OWN: begin
          if (!m_cyc[own]) begin
            gnt <= '0;
            if (cnt_nxt == '0) begin
              st <= IDLE;
              rr <= inc_mod(own);
            end else begin
              st <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt_nxt == '0) begin
            st <= IDLE;
            rr <= inc_mod(own);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_pipelined.sv
// Directed bench for wb_arbiter_pipelined: two queued masters with a scoreboard,
// a behavioural slave with programmable ACK latency, stall and stray ACK injection.
module tb_wb_arbiter_pipelined;

  localparam int NM     = 2;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int MAXOUT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NM-1:0]     m_cyc = '0;
  logic [NM-1:0]     m_stb = '0;
  logic [NM-1:0]     m_we = '0;
  logic [NM*AW-1:0]  m_adr = '0;
  logic [NM*DW-1:0]  m_dat_w = '0;
  logic [DW-1:0]     m_dat_r;
  logic [NM-1:0]     m_ack;
  logic [NM-1:0]     m_stall;
  logic [NM-1:0]     gnt;
  logic              s_cyc;
  logic              s_stb;
  logic              s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_w;
  logic [DW-1:0]     s_dat_r = '0;
  logic              s_ack = 1'b0;
  logic              s_stall = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter_pipelined #(.NM(NM), .AW(AW), .DW(DW), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_stall(m_stall), .gnt(gnt),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] dat;
  } exp_t;

  typedef struct {
    int            wt;
    logic [DW-1:0] dat;
  } pend_t;

  req_t          req_q[NM][$];
  exp_t          sb_q[NM][$];
  pend_t         pend_q[$];
  logic [NM-1:0] cyc_en = '0;
  logic [DW-1:0] ref_mem[256];
  logic [DW-1:0] slv_mem[256];
  int            lat = 1;
  int            max_pend = 0;
  logic          stall_force = 1'b0;
  logic          spur_ack = 1'b0;
  logic          model_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Master side: scoreboard push on acceptance, pop/compare on ACK, drive after the edge.
  always @(posedge clk) begin
    exp_t e;
    req_t r;
    if (rst) begin
      for (int i = 0; i < NM; i++) begin
        req_q[i].delete();
        sb_q[i].delete();
      end
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (m_ack[i]) begin
          if (sb_q[i].size() == 0) begin
            check($sformatf("m%0d_unexpected_ack", i), 32'(m_ack[i]), 32'd0);
          end else begin
            e = sb_q[i].pop_front();
            if (!e.we) check($sformatf("m%0d_read_data", i), 32'(m_dat_r), 32'(e.dat));
          end
        end
        if (m_stb[i] && !m_stall[i] && req_q[i].size() > 0) begin
          r = req_q[i].pop_front();
          if (r.we) begin
            ref_mem[r.adr[7:0]] = r.dat;
            sb_q[i].push_back({1'b1, r.dat});
          end else begin
            sb_q[i].push_back({1'b0, ref_mem[r.adr[7:0]]});
          end
        end
      end
    end
    #2;
    for (int i = 0; i < NM; i++) begin
      m_cyc[i] = cyc_en[i];
      m_stb[i] = cyc_en[i] && (req_q[i].size() > 0);
      if (req_q[i].size() > 0) begin
        m_we[i]             = req_q[i][0].we;
        m_adr[i*AW +: AW]   = req_q[i][0].adr;
        m_dat_w[i*DW +: DW] = req_q[i][0].dat;
      end else begin
        m_we[i]             = 1'b0;
        m_adr[i*AW +: AW]   = '0;
        m_dat_w[i*DW +: DW] = '0;
      end
    end
  end

  // Slave: ACK arrives lat cycles after acceptance, in order.
  always @(posedge clk) begin
    pend_t p;
    if (rst) begin
      pend_q.delete();
      model_ack = 1'b0;
    end else begin
      if (model_ack) void'(pend_q.pop_front());
      foreach (pend_q[k]) if (pend_q[k].wt > 0) pend_q[k].wt = pend_q[k].wt - 1;
      if (s_cyc && s_stb && !s_stall) begin
        p.wt = lat - 1;
        if (s_we) begin
          slv_mem[s_adr[7:0]] = s_dat_w;
          p.dat = '0;
        end else begin
          p.dat = slv_mem[s_adr[7:0]];
        end
        pend_q.push_back(p);
        if (pend_q.size() > max_pend) max_pend = pend_q.size();
      end
    end
    #2;
    model_ack = (pend_q.size() > 0) && (pend_q[0].wt == 0);
    s_ack     = model_ack | spur_ack;
    s_dat_r   = model_ack ? pend_q[0].dat : '0;
    s_stall   = stall_force;
  end

  task automatic push_req(input int m, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat);
    req_t r;
    r.we  = we;
    r.adr = adr;
    r.dat = dat;
    req_q[m].push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int m, input int budget);
    int n = 0;
    while ((req_q[m].size() > 0 || sb_q[m].size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("m%0d_done_timeout", m), 32'(req_q[m].size() + sb_q[m].size()), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    rst    = 1'b1;
    cyc_en = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'(i * 7 + 3);
      slv_mem[i] = 16'(i * 7 + 3);
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_s_cyc", 32'(s_cyc), 32'd0);
    check("rst_s_stb", 32'(s_stb), 32'd0);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_cnt", 32'(dut.cnt), 32'd0);
    tick();
    rst = 1'b0;

    // 1: m0 alone, four writes, zero-wait slave
    tick();
    for (int k = 0; k < 4; k++) push_req(0, 1'b1, 16'h0020 + 16'(k), 16'h1000 + 16'(k));
    cyc_en[0] = 1'b1;
    @(negedge clk);
    check("t1_bubble_gnt", 32'(gnt), 32'd0);
    check("t1_bubble_stall", 32'(m_stall), 32'b01);
    check("t1_bubble_s_cyc", 32'(s_cyc), 32'd0);
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'b01);
    check("t1_s_stb", 32'(s_stb), 32'd1);
    check("t1_s_we", 32'(s_we), 32'd1);
    check("t1_s_adr", 32'(s_adr), 32'h0020);
    check("t1_s_dat_w", 32'(s_dat_w), 32'h1000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t1_ack%0d", k), 32'(m_ack), 32'b01);
    end
    wait_done(0, 20);
    check("t1_cnt_end", 32'(dut.cnt), 32'd0);
    cyc_en[0] = 1'b0;
    @(negedge clk);
    check("t1_gnt_tail", 32'(gnt), 32'b01);
    @(negedge clk);
    check("t1_idle_gnt", 32'(gnt), 32'd0);
    check("t1_idle_s_cyc", 32'(s_cyc), 32'd0);

    // 2: simultaneous requests, round-robin fairness
    do_reset();
    push_req(0, 1'b1, 16'h0021, 16'hBEEF);
    push_req(0, 1'b0, 16'h0021, 16'h0000);
    push_req(1, 1'b0, 16'h0021, 16'h0000);
    push_req(1, 1'b0, 16'h0022, 16'h0000);
    cyc_en = 2'b11;
    @(negedge clk);
    check("t2_bubble_gnt", 32'(gnt), 32'd0);
    check("t2_bubble_stall", 32'(m_stall), 32'b11);
    @(negedge clk);
    check("t2_first_gnt", 32'(gnt), 32'b01);
    check("t2_first_stall", 32'(m_stall), 32'b10);
    wait_done(0, 20);
    cyc_en[0] = 1'b0;
    tick();
    push_req(0, 1'b1, 16'h0030, 16'h5A5A);
    cyc_en[0] = 1'b1;
    @(negedge clk);
    check("t2_handoff_gnt", 32'(gnt), 32'd0);
    check("t2_handoff_stall", 32'(m_stall), 32'b11);
    @(negedge clk);
    check("t2_tie_gnt_m1", 32'(gnt), 32'b10);
    check("t2_tie_stall", 32'(m_stall), 32'b01);
    wait_done(1, 20);
    cyc_en[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_idle2_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    check("t2_back_to_m0", 32'(gnt), 32'b01);
    wait_done(0, 20);
    cyc_en[0] = 1'b0;
    tick();
    tick();

    // 3: outstanding limit with 3-cycle ACK latency
    lat      = 3;
    max_pend = 0;
    for (int k = 0; k < 4; k++) push_req(0, 1'b0, 16'h0020 + 16'(k), 16'h0000);
    cyc_en[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_gnt", 32'(gnt), 32'b01);
    check("t3_stb0", 32'(s_stb), 32'd1);
    @(negedge clk);
    check("t3_stb1", 32'(s_stb), 32'd1);
    check("t3_cnt1", 32'(dut.cnt), 32'd1);
    @(negedge clk);
    check("t3_limit_stb", 32'(s_stb), 32'd0);
    check("t3_limit_stall", 32'(m_stall), 32'b01);
    check("t3_limit_cnt", 32'(dut.cnt), 32'd2);
    @(negedge clk);
    check("t3_ack_stb", 32'(s_stb), 32'd0);
    check("t3_ack_m_ack", 32'(m_ack), 32'b01);
    @(negedge clk);
    check("t3_both_stb", 32'(s_stb), 32'd1);
    check("t3_both_ack", 32'(m_ack), 32'b01);
    check("t3_both_cnt", 32'(dut.cnt), 32'd1);
    @(negedge clk);
    check("t3_cnt_kept", 32'(dut.cnt), 32'd1);
    wait_done(0, 40);
    check("t3_max_pend", 32'(max_pend), 32'd2);
    cyc_en[0] = 1'b0;
    tick();
    tick();

    // 4: owner aborts with two strobes outstanding
    for (int k = 0; k < 3; k++) push_req(0, 1'b0, 16'h0020 + 16'(k), 16'h0000);
    cyc_en[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_gnt", 32'(gnt), 32'b01);
    @(negedge clk);
    tick();
    cyc_en[0] = 1'b0;
    req_q[0].delete();
    sb_q[0].delete();
    @(negedge clk);
    check("t4_exit_cnt", 32'(dut.cnt), 32'd2);
    check("t4_exit_s_stb", 32'(s_stb), 32'd0);
    @(negedge clk);
    check("t4_drain_s_cyc", 32'(s_cyc), 32'd1);
    check("t4_drain_s_stb", 32'(s_stb), 32'd0);
    check("t4_drain_gnt", 32'(gnt), 32'd0);
    check("t4_drain_ack0", 32'(m_ack), 32'd0);
    @(negedge clk);
    check("t4_drain_ack1", 32'(m_ack), 32'd0);
    check("t4_drain_s_cyc1", 32'(s_cyc), 32'd1);
    check("t4_drain_cnt1", 32'(dut.cnt), 32'd1);
    @(negedge clk);
    check("t4_idle_s_cyc", 32'(s_cyc), 32'd0);
    check("t4_idle_cnt", 32'(dut.cnt), 32'd0);
    lat = 1;
    tick();

    // 5: asynchronous reset mid-burst
    for (int k = 0; k < 6; k++) push_req(0, 1'b1, 16'h0040 + 16'(k), 16'h7700 + 16'(k));
    cyc_en[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_gnt", 32'(gnt), 32'b01);
    @(negedge clk);
    #2;
    rst    = 1'b1;
    cyc_en = '0;
    for (int i = 0; i < NM; i++) begin
      req_q[i].delete();
      sb_q[i].delete();
    end
    #1;
    check("t5_async_gnt", 32'(gnt), 32'd0);
    check("t5_async_s_cyc", 32'(s_cyc), 32'd0);
    check("t5_async_s_stb", 32'(s_stb), 32'd0);
    check("t5_async_cnt", 32'(dut.cnt), 32'd0);
    check("t5_async_m_ack", 32'(m_ack), 32'd0);
    check("t5_async_stall", 32'(m_stall), 32'(m_stb));
    tick();
    tick();
    rst = 1'b0;
    push_req(0, 1'b0, 16'h0040, 16'h0000);
    push_req(1, 1'b0, 16'h0021, 16'h0000);
    cyc_en = 2'b11;
    @(negedge clk);
    check("t5_rearb_bubble", 32'(gnt), 32'd0);
    @(negedge clk);
    check("t5_rearb_m0", 32'(gnt), 32'b01);
    wait_done(0, 20);
    cyc_en[0] = 1'b0;
    wait_done(1, 20);
    cyc_en[1] = 1'b0;
    tick();
    tick();

    // 6: stray ACK while idle, then slave stall in OWN
    spur_ack = 1'b1;
    @(negedge clk);
    check("t6_spur_m_ack", 32'(m_ack), 32'd0);
    check("t6_spur_gnt", 32'(gnt), 32'd0);
    tick();
    spur_ack = 1'b0;
    @(negedge clk);
    check("t6_spur_cnt", 32'(dut.cnt), 32'd0);
    stall_force = 1'b1;
    push_req(0, 1'b1, 16'h0050, 16'h1111);
    cyc_en[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_stall_gnt", 32'(gnt), 32'b01);
    check("t6_stall_m_stall", 32'(m_stall), 32'b01);
    tick();
    stall_force = 1'b0;
    @(negedge clk);
    check("t6_unstall_m_stall", 32'(m_stall), 32'd0);
    check("t6_unstall_cnt", 32'(dut.cnt), 32'd0);
    @(negedge clk);
    check("t6_ack", 32'(m_ack), 32'b01);
    wait_done(0, 20);
    cyc_en[0] = 1'b0;
    push_req(1, 1'b0, 16'h0050, 16'h0000);
    cyc_en[1] = 1'b1;
    wait_done(1, 20);
    cyc_en[1] = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
